// File: rtl/ex_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_alu_unit
// Description : Execute-stage arithmetic unit. Add/sub/and/or resolve
//               combinationally in the issue cycle; mul runs on an iterative
//               shift-add multiplier (XLEN iterations) and stalls the
//               pipeline until the product is presented in the DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,      // asynchronous, active-low
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic [XLEN-1:0] data_o,
    output logic            zero_o,
    output logic            stall_o,
    output logic            busy_o
);

    // Iteration counter only needs to reach XLEN-1.
    localparam int               CNT_W    = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ALU control codes.
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;

    // Multiplier FSM encoding.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]      state_q,  state_d;
    logic [XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic            is_mul;
    logic            mul_issue;
    logic            in_idle;
    logic            in_busy;
    logic [XLEN-1:0] alu_result;

    assign is_mul    = (ALUCtrl_i == OP_MUL);
    // A flush in the same cycle as a new mul wins: nothing is issued.
    assign mul_issue = valid_i & is_mul & ~flush_i;
    assign in_idle   = (state_q == S_IDLE);
    assign in_busy   = (state_q == S_BUSY);

    // Single-cycle datapath; mul and invalid codes produce zero here so that
    // the issue cycle of a mul shows 0 while the pipeline is stalled.
    always_comb begin
        alu_result = '0;
        case (ALUCtrl_i)
            OP_ADD:  alu_result = data1_i + data2_i;
            OP_SUB:  alu_result = data1_i - data2_i;
            OP_AND:  alu_result = data1_i & data2_i;
            OP_OR:   alu_result = data1_i | data2_i;
            default: alu_result = '0;
        endcase
    end

    // Multiplier next-state: load operands at issue, one shift-add per BUSY
    // cycle, a single DONE cycle to present the product, flush overrides all.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mul_issue) begin
                    state_d  = S_BUSY;
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // acc is deliberately left alone: it is only ever shown in DONE,
        // which cannot be reached again without a fresh issue clearing it.
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Multiplier state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result mux: the product is visible only in DONE; BUSY shows 0 so a
    // partial accumulator never leaks onto the result bus.
    always_comb begin
        data_o = alu_result;
        case (state_q)
            S_BUSY:  data_o = '0;
            S_DONE:  data_o = acc_q;
            default: data_o = alu_result;
        endcase
    end

    assign zero_o  = (data_o == '0);
    // Stall is forced low while reset is asserted, since an issue condition
    // on the inputs must not freeze the pipeline during reset.
    assign stall_o = rst_i & ((in_idle & mul_issue) | (in_busy & ~flush_i));
    assign busy_o  = ~in_idle;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_alu_unit
// Description : Self-checking bench for ex_alu_unit. Directed cases plus a
//               randomized op stream compared against a behavioural model
//               (plain arithmetic results, latency stated in cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_alu_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = XLEN + 1;   // cycles stall_o is high per mul

    logic            clk_i;
    logic            rst_i;
    logic            valid_i;
    logic            flush_i;
    logic [2:0]      ALUCtrl_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic [XLEN-1:0] data_o;
    logic            zero_o;
    logic            stall_o;
    logic            busy_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_alu_unit #(.XLEN(XLEN)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .stall_o   (stall_o),
        .busy_o    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference result of an operation computed from its arithmetic meaning.
    function automatic logic [31:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b001:  r = a + b;
            3'b010:  r = a - b;
            3'b011:  r = a & b;
            3'b100:  r = a | b;
            3'b110:  r = a * b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h0000_0001;
            3:       v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Single-cycle (non-issuing) operation: checked combinationally, then
    // the clock advances. A mul code that does not issue must show 0.
    task automatic alu_op(input logic [2:0] op, input logic v,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        valid_i = v; flush_i = 1'b0; ALUCtrl_i = op; data1_i = a; data2_i = b;
        #1;
        exp = (op == 3'b110) ? 32'h0 : ref_result(op, a, b);
        check("alu_data",  data_o, exp);
        check("alu_zero",  32'(zero_o),  32'(exp == 32'h0));
        check("alu_stall", 32'(stall_o), 32'h0);
        step();
    endtask

    // Full multiply: counts stall cycles, scrambles operands while stalled,
    // checks the DONE product and that busy_o is low the cycle after DONE.
    // Returns just after the edge that follows DONE, ready for the next op.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic [31:0] exp;
        exp = ref_result(3'b110, a, b);
        valid_i = 1'b1; flush_i = 1'b0; ALUCtrl_i = 3'b110; data1_i = a; data2_i = b;
        #1;
        cyc = 0;
        while (stall_o === 1'b1 && cyc < 4 * MUL_LAT) begin
            cyc++;
            step();
            data1_i = $urandom;
            data2_i = $urandom;
            #1;
        end
        check("mul_stall_cycles", 32'(cyc), 32'(MUL_LAT));
        check("mul_product",      data_o, exp);
        check("mul_zero",         32'(zero_o), 32'(exp == 32'h0));
        check("mul_done_busy",    32'(busy_o), 32'h1);
        valid_i = 1'b0;
        step();
        check("mul_after_busy",   32'(busy_o), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        logic       v;

        // ---------------- reset ----------------
        rst_i = 1'b0; valid_i = 1'b1; flush_i = 1'b0;
        ALUCtrl_i = 3'b110; data1_i = 32'd9; data2_i = 32'd9;
        repeat (3) step();
        check("rst_busy",  32'(busy_o),  32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        valid_i = 1'b0; ALUCtrl_i = 3'b001;
        #1;
        check("rst_data_follows_alu", data_o, 32'd18);
        rst_i = 1'b1;
        step();

        // ---------------- directed ALU ops ----------------
        alu_op(3'b001, 1'b1, 32'h7, 32'h5);
        alu_op(3'b010, 1'b1, 32'h7, 32'h5);
        alu_op(3'b011, 1'b1, 32'h7, 32'h5);
        alu_op(3'b100, 1'b1, 32'h7, 32'h5);
        alu_op(3'b111, 1'b1, 32'h7, 32'h5);
        alu_op(3'b001, 1'b1, 32'hFFFF_FFFF, 32'h1);
        alu_op(3'b010, 1'b1, 32'h1234, 32'h1234);

        // ---------------- directed muls ----------------
        run_mul(32'h0001_0003, 32'h0000_0010);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul(32'h3, 32'h5);              // back-to-back, no bubble

        // ---------------- reset mid-BUSY ----------------
        valid_i = 1'b1; ALUCtrl_i = 3'b110; data1_i = 32'h55; data2_i = 32'h77;
        repeat (11) step();                 // now in iteration 10
        check("pre_rst_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_o), 32'h0);
        check("midrst_busy",  32'(busy_o),  32'h0);
        valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_idle_busy", 32'(busy_o), 32'h0);
        end
        alu_op(3'b011, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF);

        // ---------------- flush at iteration 5 ----------------
        valid_i = 1'b1; ALUCtrl_i = 3'b110; data1_i = 32'h99; data2_i = 32'h11;
        repeat (6) step();
        flush_i = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'h0);
        step();
        flush_i = 1'b0;
        check("flush_next_busy", 32'(busy_o), 32'h0);
        alu_op(3'b001, 1'b1, 32'h2, 32'h3);

        // ---------------- flush together with issue ----------------
        valid_i = 1'b1; flush_i = 1'b1; ALUCtrl_i = 3'b110; data1_i = 32'h4; data2_i = 32'h4;
        #1;
        check("flush_issue_stall", 32'(stall_o), 32'h0);
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_issue_busy", 32'(busy_o), 32'h0);

        // ---------------- randomized stream ----------------
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 3) != 0);
            if (op == 3'b110 && v)
                run_mul(rnd_opnd(), rnd_opnd());
            else
                alu_op(op, v, rnd_opnd(), rnd_opnd());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
